// File: rtl/intpol2_pkg.sv
// Shared definitions for the xi2 interpolation sequencer.
//   state_e      : sequencer FSM states (IDLE, CLR, STEP)
//   SEL_*        : select codes understood by the xi2 datapath
//   sel_for_step : maps step index k (1-based) to its select code
package intpol2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        STEP = 2'd2
    } state_e;

    localparam logic [1:0] SEL_ZERO  = 2'b00;
    localparam logic [1:0] SEL_LOAD  = 2'b01;
    localparam logic [1:0] SEL_LOAD4 = 2'b10;
    localparam logic [1:0] SEL_ACC   = 2'b11;

    // First step loads x2, second loads x2<<2, later steps accumulate
    // the finite differences that build n^2*x2.
    function automatic logic [1:0] sel_for_step(input int unsigned k);
        if (k == 1) begin
            return SEL_LOAD;
        end else if (k == 2) begin
            return SEL_LOAD4;
        end
        return SEL_ACC;
    endfunction

endpackage

// File: rtl/intpol2_out_slot.sv
// Single-entry valid/ready output register carrying the phase tag of
// the xi2 value currently presented downstream.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush_i       : drop any held entry (abort)
//   push_i        : load a new entry (datapath stepped this cycle)
//   push_phase_i  : phase index of the entry being loaded
//   pop_ready_i   : downstream ready
//   valid_o       : entry held
//   phase_o       : phase index of held entry
//   last_o        : phase_o == D
//   slot_free_o   : a push this cycle cannot overwrite an unconsumed entry
module intpol2_out_slot #(
    parameter int unsigned D    = 4,
    parameter int unsigned PH_W = $clog2(D + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic [PH_W-1:0] push_phase_i,
    input  logic            pop_ready_i,
    output logic            valid_o,
    output logic [PH_W-1:0] phase_o,
    output logic            last_o,
    output logic            slot_free_o
);

    logic            valid_q, valid_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        phase_d = phase_q;
        last_d  = last_q;
        if (flush_i) begin
            valid_d = 1'b0;
            phase_d = '0;
            last_d  = 1'b0;
        end else if (push_i) begin
            // Push wins over pop: a consume and a new step in the same
            // cycle simply advance the presented phase.
            valid_d = 1'b1;
            phase_d = push_phase_i;
            last_d  = (push_phase_i == PH_W'(D));
        end else if (valid_q && pop_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            phase_q <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            phase_q <= phase_d;
            last_q  <= last_d;
        end
    end

    assign valid_o     = valid_q;
    assign phase_o     = phase_q;
    assign last_o      = last_q;
    assign slot_free_o = !valid_q || pop_ready_i;

endmodule

// File: rtl/intpol2_d4_sched.sv
// Sequencer for the squared-term interpolation accumulator (xi2).
// Accepts one sample per block, pulses a datapath clear, then issues D
// datapath steps with the select sequence 01, 10, 11, ... while honouring
// output backpressure, and tags each xi2 result with its phase 1..D.
// Handshakes: a transfer happens on a cycle where valid && ready are both
// high; valid never depends on ready, and a presented entry is held
// unchanged until it transfers.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   abort      : synchronous abort of the current block
//   in_valid   : upstream sample available
//   in_ready   : idle and able to take a sample
//   x2_load    : capture strobe for the external x2 hold register
//   clear_xi2  : one-cycle datapath clear
//   en_xi2     : datapath step enable
//   sel_xi2    : datapath select code
//   out_valid  : xi2 valid for out_phase
//   out_ready  : downstream accepts xi2
//   out_phase  : phase index 1..D
//   out_last   : out_phase == D
//   busy       : block in progress or result pending
//   stall_cnt  : cycles with out_valid && !out_ready (saturating), only
//                present when INTPOL2_SCHED_STALL_CNT_EN is defined
module intpol2_d4_sched
    import intpol2_pkg::*;
#(
    parameter int unsigned D    = 4,
    parameter int unsigned PH_W = $clog2(D + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            abort,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            x2_load,
    output logic            clear_xi2,
    output logic            en_xi2,
    output logic [1:0]      sel_xi2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PH_W-1:0] out_phase,
    output logic            out_last,
    output logic            busy
`ifdef INTPOL2_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);

    if (D < 2 || D > 16) begin : g_bad_d
        $error("intpol2_d4_sched: D=%0d outside legal range 2..16", D);
    end

    state_e          state_q, state_d;
    logic [PH_W-1:0] k_q, k_d;
    // Low for the first cycle after reset so in_ready stays 0 there.
    logic            run_ok_q;
    logic            slot_free;
    logic            accept;

    assign accept  = in_valid && in_ready;
    assign x2_load = accept;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            run_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            run_ok_q <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        if (abort) begin
            state_d = IDLE;
            k_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = CLR;
                    end
                end
                CLR: begin
                    state_d = STEP;
                    k_d     = PH_W'(1);
                end
                STEP: begin
                    if (slot_free) begin
                        // k stops at D; the counter only restarts via CLR.
                        if (k_q == PH_W'(D)) begin
                            state_d = IDLE;
                        end else begin
                            k_d = k_q + PH_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        clear_xi2 = 1'b0;
        en_xi2    = 1'b0;
        sel_xi2   = SEL_ZERO;
        case (state_q)
            IDLE: in_ready = run_ok_q && !rst && !abort;
            CLR:  clear_xi2 = !rst;
            STEP: begin
                en_xi2  = slot_free && !abort && !rst;
                sel_xi2 = sel_for_step(32'(k_q));
            end
            default: ;
        endcase
        // Abort wipes partial datapath state; reset does not pulse the
        // clear because the datapath resets itself.
        if (abort && !rst) begin
            clear_xi2 = 1'b1;
        end
    end

    intpol2_out_slot #(
        .D    (D),
        .PH_W (PH_W)
    ) u_out_slot (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (abort),
        .push_i       (en_xi2),
        .push_phase_i (k_q),
        .pop_ready_i  (out_ready),
        .valid_o      (out_valid),
        .phase_o      (out_phase),
        .last_o       (out_last),
        .slot_free_o  (slot_free)
    );

    assign busy = (state_q != IDLE) || out_valid;

`ifdef INTPOL2_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (abort) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_intpol2_d4_sched.sv
// Directed bench for intpol2_d4_sched: a D=4 instance for the main
// scenarios and a D=2 instance for the short-sequence case. A small
// xi2 datapath model driven by the DUT strobes gives the xi2 values
// that are compared with hand-computed k^2*x2 results.
module tb_intpol2_d4_sched;

    logic        clk = 1'b0;
    logic        rst;
    int          errors = 0;
    int          checks = 0;

    // D=4 instance
    logic        abort, in_valid, in_ready, x2_load, clear_xi2, en_xi2;
    logic [1:0]  sel_xi2;
    logic        out_valid, out_ready, out_last, busy;
    logic [2:0]  out_phase;
    // D=2 instance
    logic        abort2, in_valid2, in_ready2, x2_load2, clear_xi22, en_xi22;
    logic [1:0]  sel_xi22;
    logic        out_valid2, out_ready2, out_last2, busy2;
    logic [1:0]  out_phase2;
`ifdef INTPOL2_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt, stall_cnt2;
`endif

    logic [15:0] x2;
    logic [15:0] x2_hold, xi2_m, dlt_m;
    logic [1:0]  sel_tab [4] = '{2'b01, 2'b10, 2'b11, 2'b11};

    always #5 clk = ~clk;

    intpol2_d4_sched #(.D(4)) u_dut (
        .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .x2_load(x2_load), .clear_xi2(clear_xi2), .en_xi2(en_xi2), .sel_xi2(sel_xi2),
        .out_valid(out_valid), .out_ready(out_ready), .out_phase(out_phase),
        .out_last(out_last), .busy(busy)
`ifdef INTPOL2_SCHED_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    intpol2_d4_sched #(.D(2)) u_dut2 (
        .clk(clk), .rst(rst), .abort(abort2), .in_valid(in_valid2), .in_ready(in_ready2),
        .x2_load(x2_load2), .clear_xi2(clear_xi22), .en_xi2(en_xi22), .sel_xi2(sel_xi22),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_phase(out_phase2),
        .out_last(out_last2), .busy(busy2)
`ifdef INTPOL2_SCHED_STALL_CNT_EN
        , .stall_cnt(stall_cnt2)
`endif
    );

    // xi2 datapath model: load x2, load 4*x2, then add growing odd multiples.
    always @(posedge clk) begin
        if (x2_load) x2_hold <= x2;
        if (clear_xi2) begin
            xi2_m <= 16'd0;
            dlt_m <= 16'd0;
        end else if (en_xi2) begin
            case (sel_xi2)
                2'b01: begin xi2_m <= x2_hold; dlt_m <= x2_hold; end
                2'b10: begin xi2_m <= 16'(x2_hold << 2); dlt_m <= 16'(3 * x2_hold); end
                2'b11: begin
                    dlt_m <= 16'(dlt_m + 2 * x2_hold);
                    xi2_m <= 16'(xi2_m + dlt_m + 2 * x2_hold);
                end
                default: ;
            endcase
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(in_ready && !busy) && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (!(in_ready === 1'b1 && busy === 1'b0)) begin
            errors++;
            $display("FAIL wait_idle: in_ready=%0b busy=%0b after %0d cycles, want 1/0", in_ready, busy, n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if ({in_ready, x2_load, clear_xi2, en_xi2, sel_xi2, out_valid, out_phase, out_last, busy} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0", {in_ready, x2_load, clear_xi2, en_xi2, sel_xi2, out_valid, out_phase, out_last, busy});
        end
        checks++; if (in_ready2 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL reset_d2: in_ready2=%0b busy2=%0b want 0/0", in_ready2, busy2); end
        @(negedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_single(input int x2v);
        logic       exp_en;
        logic [1:0] exp_sel;
        wait_idle();
        @(negedge clk); in_valid = 1'b1; x2 = 16'(x2v); #1;
        checks++; if ({in_ready, x2_load} !== 2'b11) begin errors++; $display("FAIL single_accept: in_ready/x2_load=%b want 11", {in_ready, x2_load}); end
        @(negedge clk); in_valid = 1'b0; #1;
        checks++; if ({clear_xi2, en_xi2, in_ready, busy} !== 4'b1001) begin errors++; $display("FAIL single_clear: clr/en/rdy/busy=%b want 1001", {clear_xi2, en_xi2, in_ready, busy}); end
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk); #1;
            exp_en  = (i < 4);
            exp_sel = (i < 4) ? sel_tab[i] : 2'b00;
            checks++;
            if ({en_xi2, sel_xi2} !== {exp_en, exp_sel}) begin
                errors++;
                $display("FAIL single_step%0d: en/sel=%b want %b", i, {en_xi2, sel_xi2}, {exp_en, exp_sel});
            end
            checks++; if (out_valid !== (i >= 1)) begin errors++; $display("FAIL single_valid%0d: got %0b want %0b", i, out_valid, (i >= 1)); end
            if (i >= 1) begin
                checks++;
                if ({out_phase, out_last} !== {3'(i), (i == 4)}) begin
                    errors++;
                    $display("FAIL single_phase%0d: phase=%0d last=%0b want %0d/%0b", i, out_phase, out_last, i, (i == 4));
                end
                checks++; if (xi2_m !== 16'(i * i * x2v)) begin errors++; $display("FAIL single_xi2_%0d: got %0d want %0d", i, xi2_m, i * i * x2v); end
            end
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_idle_ready: got %0b want 1", in_ready); end
        @(negedge clk); #1;
        checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL single_drain: valid/busy=%b want 00", {out_valid, busy}); end
    endtask

    task automatic test_backpressure();
        wait_idle();
        @(negedge clk); in_valid = 1'b1; x2 = 16'd2; #1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if ({en_xi2, sel_xi2, out_valid, out_phase} !== {1'b1, 2'b10, 1'b1, 3'd1}) begin errors++; $display("FAIL bp_pre: en/sel/valid/phase=%b want 1101001", {en_xi2, sel_xi2, out_valid, out_phase}); end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); out_ready = 1'b0; #1;
            checks++;
            if ({out_valid, out_phase, en_xi2, sel_xi2} !== {1'b1, 3'd2, 1'b0, 2'b11}) begin
                errors++;
                $display("FAIL bp_hold%0d: valid/phase/en/sel=%b want 1010011", j, {out_valid, out_phase, en_xi2, sel_xi2});
            end
            checks++; if (xi2_m !== 16'd8) begin errors++; $display("FAIL bp_xi2_hold%0d: got %0d want 8", j, xi2_m); end
        end
        @(negedge clk); out_ready = 1'b1; #1;
        checks++; if ({out_valid, out_phase, en_xi2, sel_xi2} !== {1'b1, 3'd2, 1'b1, 2'b11}) begin errors++; $display("FAIL bp_release: valid/phase/en/sel=%b want 1010111", {out_valid, out_phase, en_xi2, sel_xi2}); end
`ifdef INTPOL2_SCHED_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL bp_stall_cnt: got %0d want 3", stall_cnt); end
`endif
        @(negedge clk); #1;
        checks++; if ({out_phase, xi2_m, en_xi2} !== {3'd3, 16'd18, 1'b1}) begin errors++; $display("FAIL bp_phase3: phase=%0d xi2=%0d en=%0b want 3/18/1", out_phase, xi2_m, en_xi2); end
        @(negedge clk); #1;
        checks++; if ({out_phase, out_last, xi2_m, en_xi2} !== {3'd4, 1'b1, 16'd32, 1'b0}) begin errors++; $display("FAIL bp_phase4: phase=%0d last=%0b xi2=%0d en=%0b want 4/1/32/0", out_phase, out_last, xi2_m, en_xi2); end
    endtask

    task automatic test_back_to_back();
        int loads = 0;
        wait_idle();
        x2 = 16'd1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk); in_valid = 1'b1; #1;
            checks++;
            if ({in_ready, x2_load} !== {(i % 6 == 0), (i % 6 == 0)}) begin
                errors++;
                $display("FAIL b2b_cycle%0d: in_ready/x2_load=%b want %b", i, {in_ready, x2_load}, {(i % 6 == 0), (i % 6 == 0)});
            end
            if (x2_load === 1'b1) loads++;
        end
        @(negedge clk); in_valid = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_final_ready: got %0b want 1", in_ready); end
        checks++; if (loads !== 3) begin errors++; $display("FAIL b2b_loads: got %0d want 3", loads); end
    endtask

    task automatic test_abort();
        wait_idle();
        @(negedge clk); in_valid = 1'b1; x2 = 16'd4;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if ({en_xi2, sel_xi2} !== 3'b110) begin errors++; $display("FAIL abort_pre: en/sel=%b want 110", {en_xi2, sel_xi2}); end
        @(negedge clk); abort = 1'b1; in_valid = 1'b1; x2 = 16'd9; #1;
        checks++;
        if ({clear_xi2, en_xi2, in_ready, x2_load} !== 4'b1000) begin
            errors++;
            $display("FAIL abort_cycle: clr/en/rdy/load=%b want 1000", {clear_xi2, en_xi2, in_ready, x2_load});
        end
        @(negedge clk); abort = 1'b0; in_valid = 1'b0; #1;
        checks++; if ({out_valid, busy, in_ready, clear_xi2} !== 4'b0010) begin errors++; $display("FAIL abort_after: valid/busy/rdy/clr=%b want 0010", {out_valid, busy, in_ready, clear_xi2}); end
`ifdef INTPOL2_SCHED_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL abort_stall_cnt: got %0d want 0", stall_cnt); end
`endif
    endtask

    task automatic test_rst_mid();
        wait_idle();
        @(negedge clk); in_valid = 1'b1; x2 = 16'd7;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1; #1;
        checks++; if ({in_ready, clear_xi2, en_xi2} !== 3'b000) begin errors++; $display("FAIL rstmid_during: rdy/clr/en=%b want 000", {in_ready, clear_xi2, en_xi2}); end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if ({in_ready, x2_load, clear_xi2, en_xi2, sel_xi2, out_valid, out_phase, out_last, busy} !== 11'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %b want 0", {in_ready, x2_load, clear_xi2, en_xi2, sel_xi2, out_valid, out_phase, out_last, busy});
        end
`ifdef INTPOL2_SCHED_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_stall_cnt: got %0d want 0", stall_cnt); end
`endif
        @(negedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_d2();
        int         n = 0;
        int         m;
        logic       exp_ov;
        logic [1:0] exp_sel;
        while (!(in_ready2 && !busy2) && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        checks++; if ({in_ready2, busy2} !== 2'b10) begin errors++; $display("FAIL d2_idle: rdy/busy=%b want 10", {in_ready2, busy2}); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); in_valid2 = 1'b1; #1;
            m = i % 4;
            exp_sel = (m == 2) ? 2'b01 : ((m == 3) ? 2'b10 : 2'b00);
            exp_ov  = (i >= 3) && (m == 3 || m == 0);
            checks++;
            if ({in_ready2, x2_load2, en_xi22, sel_xi22, out_valid2} !== {(m == 0), (m == 0), (m >= 2), exp_sel, exp_ov}) begin
                errors++;
                $display("FAIL d2_cycle%0d: rdy/load/en/sel/valid=%b want %b", i, {in_ready2, x2_load2, en_xi22, sel_xi22, out_valid2},
                         {(m == 0), (m == 0), (m >= 2), exp_sel, exp_ov});
            end
            if (exp_ov) begin
                checks++;
                if ({out_phase2, out_last2} !== {((m == 3) ? 2'd1 : 2'd2), (m == 0)}) begin
                    errors++;
                    $display("FAIL d2_phase%0d: phase=%0d last=%0b want %0d/%0b", i, out_phase2, out_last2, (m == 3) ? 1 : 2, (m == 0));
                end
            end
        end
        @(negedge clk); in_valid2 = 1'b0; #1;
        checks++; if ({in_ready2, out_valid2, out_phase2, out_last2} !== 5'b11101) begin errors++; $display("FAIL d2_end: rdy/valid/phase/last=%b want 11101", {in_ready2, out_valid2, out_phase2, out_last2}); end
        // Stall the D=2 output for five cycles with phase 1 presented.
        @(negedge clk); in_valid2 = 1'b1; out_ready2 = 1'b0; #1;
        checks++; if (x2_load2 !== 1'b1) begin errors++; $display("FAIL d2_stall_accept: got %0b want 1", x2_load2); end
        @(negedge clk); in_valid2 = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk); #1;
            checks++;
            if ({out_valid2, out_phase2, en_xi22, sel_xi22} !== {1'b1, 2'd1, 1'b0, 2'b10}) begin
                errors++;
                $display("FAIL d2_stall%0d: valid/phase/en/sel=%b want 101010", j, {out_valid2, out_phase2, en_xi22, sel_xi22});
            end
        end
        @(negedge clk); out_ready2 = 1'b1; #1;
        checks++; if ({en_xi22, sel_xi22} !== 3'b110) begin errors++; $display("FAIL d2_resume: en/sel=%b want 110", {en_xi22, sel_xi22}); end
`ifdef INTPOL2_SCHED_STALL_CNT_EN
        checks++; if (stall_cnt2 !== 16'd5) begin errors++; $display("FAIL d2_stall_cnt: got %0d want 5", stall_cnt2); end
`endif
        @(negedge clk); #1;
        checks++; if ({out_valid2, out_phase2, out_last2} !== 4'b1101) begin errors++; $display("FAIL d2_last: valid/phase/last=%b want 1101", {out_valid2, out_phase2, out_last2}); end
    endtask

    initial begin
        rst = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x2 = 16'd0;
        abort2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1;
        test_reset();
        test_single(3);
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_single(5);
        test_rst_mid();
        test_d2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
